// File: rtl/muxn_scan.sv
// Purpose: N:1 mux of W-bit channels, manual (sel) or round-robin scan over en_mask.
// Latency: 1 cycle from sampled din to y; registered outputs only.
// Backpressure: out_valid & !out_ready holds y/y_ch/out_valid/ptr; all inputs ignored meanwhile.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   mode            0 = manual (sel), 1 = round-robin scan over en_mask
//   sel             channel index for manual mode (values >= N select nothing)
//   en_mask         per-channel enables for scan mode
//   din             packed channels, channel k = din[k*W +: W]
//   out_ready       consumer accepts the current sample
//   out_valid/y/y_ch  captured sample and the channel it came from
module muxn_scan #(
    parameter int N    = 8,
    parameter int W    = 1,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [N-1:0]    en_mask,
    input  logic [N*W-1:0]  din,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [W-1:0]    y,
    output logic [SELW-1:0] y_ch
);

    // Channel table padded to the full sel range so any sel value indexes
    // cleanly; padded slots are flagged as not selectable.
    localparam int NSEL = 1 << SELW;

    logic [W-1:0]    ch [NSEL];
    logic [NSEL-1:0] sel_in_range;

    genvar k;
    generate
        for (k = 0; k < NSEL; k++) begin : g_ch
            if (k < N) begin : g_real
                assign ch[k]           = din[k*W +: W];
                assign sel_in_range[k] = 1'b1;
            end else begin : g_pad
                assign ch[k]           = '0;
                assign sel_in_range[k] = 1'b0;
            end
        end
    endgenerate

    logic [SELW-1:0] ptr;

    // Circular search from ptr: rotate the mask so ptr lands on bit 0, find
    // the lowest set bit, then add ptr back modulo N.
    logic [2*N-1:0]  mask_dbl;
    logic [N-1:0]    mask_rot;
    logic            scan_hit;
    logic [SELW-1:0] scan_off;
    logic [SELW:0]   scan_sum;
    logic [SELW-1:0] scan_c;
    logic [SELW-1:0] scan_next;

    assign mask_dbl = {en_mask, en_mask} >> ptr;
    assign mask_rot = mask_dbl[N-1:0];

    always_comb begin
        scan_hit = 1'b0;
        scan_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_rot[i]) begin
                scan_hit = 1'b1;
                scan_off = SELW'(i);
            end
        end
    end

    always_comb begin
        scan_sum = {1'b0, ptr} + {1'b0, scan_off};
        if (scan_sum >= (SELW+1)'(N)) begin
            scan_sum = scan_sum - (SELW+1)'(N);
        end
        scan_c = scan_sum[SELW-1:0];
    end

    assign scan_next = (scan_c == SELW'(N - 1)) ? '0 : scan_c + SELW'(1);

    logic            pick_vld;
    logic [SELW-1:0] pick_c;
    logic            slot_free;

    assign pick_vld  = mode ? scan_hit : sel_in_range[sel];
    assign pick_c    = mode ? scan_c   : sel;
    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            y_ch      <= '0;
            ptr       <= '0;
        end else if (slot_free) begin
            if (pick_vld) begin
                out_valid <= 1'b1;
                y         <= ch[pick_c];
                y_ch      <= pick_c;
                // ptr only moves on scan loads, so it survives manual phases.
                if (mode) begin
                    ptr <= scan_next;
                end
            end else begin
                // Nothing to offer: drop valid but keep the last sample visible.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muxn_scan.sv
module tb_muxn_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  en_mask;
    logic [63:0] din;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  y;
    logic [2:0]  y_ch;

    logic        mode6;
    logic [2:0]  sel6;
    logic [5:0]  en6;
    logic [47:0] din6;
    logic        rdy6;
    logic        vld6;
    logic [7:0]  y6;
    logic [2:0]  ych6;

    always #5 clk = ~clk;

    muxn_scan #(.N(8), .W(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .en_mask(en_mask),
        .din(din), .out_ready(out_ready), .out_valid(out_valid), .y(y), .y_ch(y_ch)
    );

    muxn_scan #(.N(6), .W(8)) dut6 (
        .clk(clk), .rst(rst), .mode(mode6), .sel(sel6), .en_mask(en6),
        .din(din6), .out_ready(rdy6), .out_valid(vld6), .y(y6), .y_ch(ych6)
    );

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] d;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0;
    int   nerr = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] c, input logic [7:0] d);
        exp_t e;
        e.ch = c;
        e.d  = d;
        q.push_back(e);
    endtask

    task automatic set_din(input logic [7:0] base);
        for (int k = 0; k < 8; k++) din[k*8 +: 8] = base + 8'(k);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every handshake (valid & ready before the edge)
    // consumes one expected sample.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (q.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL unexpected_sample: got ch=%0d y=%0h, expected nothing", y_ch, y);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_y_ch", 32'(y_ch), 32'(e.ch));
                chk("sb_y", 32'(y), 32'(e.d));
            end
        end
    end

    initial begin
        mode      = 1'b1;
        sel       = 3'd0;
        en_mask   = 8'h00;
        out_ready = 1'b1;
        set_din(8'h10);
        mode6 = 1'b0;
        sel6  = 3'd7;
        en6   = 6'h00;
        rdy6  = 1'b1;
        for (int k = 0; k < 6; k++) din6[k*8 +: 8] = 8'h10 + 8'(k);

        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_y_ch", 32'(y_ch), 32'd0);

        // Test 1: reset mid-stream in scan mode.
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        en_mask = 8'hFF;
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_y", 32'(y), 32'd0);
        chk("midrst_y_ch", 32'(y_ch), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Test 3: full mask scan; first capture after reset is channel 0.
        for (int i = 0; i < 10; i++) push(3'(i % 8), 8'h10 + 8'(i % 8));
        repeat (10) step();
        en_mask = 8'h00;
        step();
        chk("t3_idle_valid", 32'(out_valid), 32'd0);

        // Test 2: manual mode.
        mode = 1'b0;
        sel  = 3'd5;
        push(3'd5, 8'h15);
        step();
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_y", 32'(y), 32'h15);
        chk("t2_y_ch", 32'(y_ch), 32'd5);
        sel = 3'd2;
        push(3'd2, 8'h12);
        step();
        chk("t2_y_sel2", 32'(y), 32'h12);
        mode = 1'b1;
        step();

        // Test 4: sparse mask, scan resumes from stored ptr (2).
        en_mask = 8'b1010_0100;
        push(3'd2, 8'h12);
        push(3'd5, 8'h15);
        push(3'd7, 8'h17);
        push(3'd2, 8'h12);
        push(3'd5, 8'h15);
        repeat (5) step();
        en_mask = 8'h00;
        step();
        chk("t4_drop_valid", 32'(out_valid), 32'd0);
        chk("t4_keep_y", 32'(y), 32'h15);
        chk("t4_keep_y_ch", 32'(y_ch), 32'd5);

        // Test 5: backpressure with changing din; ptr is 6 here.
        en_mask = 8'hFF;
        push(3'd6, 8'h16);
        step();
        out_ready = 1'b0;
        set_din(8'h50);
        step();
        chk("t5_hold_y_a", 32'(y), 32'h16);
        chk("t5_hold_ch_a", 32'(y_ch), 32'd6);
        chk("t5_hold_vld_a", 32'(out_valid), 32'd1);
        set_din(8'h70);
        step();
        chk("t5_hold_y_b", 32'(y), 32'h16);
        chk("t5_hold_ch_b", 32'(y_ch), 32'd6);
        set_din(8'h90);
        step();
        chk("t5_hold_y_c", 32'(y), 32'h16);
        chk("t5_hold_ch_c", 32'(y_ch), 32'd6);
        out_ready = 1'b1;
        push(3'd7, 8'h97);
        step();
        chk("t5_next_ch", 32'(y_ch), 32'd7);
        en_mask = 8'h00;
        step();

        // Test 6: N=6 instance, out-of-range sel.
        chk("t6_init_valid", 32'(vld6), 32'd0);
        sel6 = 3'd1;
        step();
        chk("t6_load_valid", 32'(vld6), 32'd1);
        chk("t6_load_y", 32'(y6), 32'h11);
        sel6 = 3'd7;
        step();
        chk("t6_oor_valid", 32'(vld6), 32'd0);
        chk("t6_oor_keep_y", 32'(y6), 32'h11);
        chk("t6_oor_keep_ch", 32'(ych6), 32'd1);
        sel6 = 3'd3;
        step();
        chk("t6_sel3_valid", 32'(vld6), 32'd1);
        chk("t6_sel3_ch", 32'(ych6), 32'd3);
        chk("t6_sel3_y", 32'(y6), 32'h13);

        step();
        chk("sb_queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
